// File: rtl/lzs_pkg.sv
// Shared constants and state encoding for the LZS bit-stream front end.
// The state width matches the decoder's current_state register.
package lzs_pkg;

   localparam int IN_WIDTH       = 13;
   localparam int NEED_STR_WIDTH = 4;
   localparam int WORD_WIDTH     = 32;
   localparam int BUF_WIDTH      = 64;
   localparam int CNT_WIDTH      = 7;
   localparam int WORD_BYTES     = WORD_WIDTH / 8;

   typedef enum logic [2:0] {
      S_FILL  = 3'd0,
      S_RUN   = 3'd1,
      S_DRAIN = 3'd2,
      S_DONE  = 3'd3
   } state_t;

   // Only the final word may be partial; out-of-range keep values saturate to a full word.
   function automatic logic [2:0] keep_bytes(input logic last, input logic [2:0] keep);
      if (!last)
         return 3'(WORD_BYTES);
      return (keep > 3'(WORD_BYTES)) ? 3'(WORD_BYTES) : keep;
   endfunction

endpackage

// File: rtl/lzs_word_align.sv
// Masks the unused tail bytes of an input word and right-aligns it to the
// first free bit position of the left-justified shift buffer.
module lzs_word_align
   import lzs_pkg::*;
(
   input  logic [WORD_WIDTH-1:0] word,
   input  logic [2:0]            nbytes,
   input  logic [CNT_WIDTH-1:0]  pos,
   output logic [BUF_WIDTH-1:0]  ins
);

   logic [WORD_WIDTH-1:0] mask;

   always_comb begin
      mask = '0;
      for (int i = 0; i < WORD_BYTES; i++)
         if (3'(i) < nbytes)
            mask[WORD_WIDTH-1-8*i -: 8] = 8'hFF;
      ins = {word & mask, {(BUF_WIDTH-WORD_WIDTH){1'b0}}} >> pos;
   end

endmodule

// File: rtl/lzs_bit_stream.sv
// Bit-stream feeder: packs 32-bit words into a 64-bit left-justified shift
// buffer and presents a 13-bit MSB-first look-ahead window to the decoder.
module lzs_bit_stream
   import lzs_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      in_valid,
   input  logic [WORD_WIDTH-1:0]     in_data,
   input  logic [2:0]                in_keep,
   input  logic                      in_last,
   output logic                      in_ready,
   output logic                      stream_valid,
   output logic [IN_WIDTH-1:0]       stream_data,
   output logic                      stream_empty,
   input  logic                      stream_ack,
   input  logic [NEED_STR_WIDTH-1:0] stream_width,
   output logic [CNT_WIDTH-1:0]      bits_avail
);

   localparam logic [CNT_WIDTH-1:0] WIN_BITS  = CNT_WIDTH'(IN_WIDTH);
   localparam logic [CNT_WIDTH-1:0] LOAD_MAX  = CNT_WIDTH'(BUF_WIDTH - WORD_WIDTH);

   state_t                    state, state_nxt;
   logic [BUF_WIDTH-1:0]      shbuf, buf_nxt, ins;
   logic [CNT_WIDTH-1:0]      cnt, cnt_sh, cnt_nxt, w, add;
   logic                      ended, ended_nxt;
   logic [NEED_STR_WIDTH-1:0] w_req;
   logic [2:0]                nbytes;
   logic                      load, do_ack;

   // Handshake outputs depend on registered state only.
   always_comb begin
      in_ready     = 1'b0;
      stream_valid = 1'b0;
      stream_empty = 1'b0;
      case (state)
         S_FILL, S_RUN: begin
            in_ready     = (cnt <= LOAD_MAX);
            stream_valid = (cnt >= WIN_BITS);
         end
         S_DRAIN: stream_valid = (cnt != '0);
         S_DONE:  stream_empty = 1'b1;
         default: ;
      endcase
   end

   assign stream_data = shbuf[BUF_WIDTH-1 -: IN_WIDTH];
   assign bits_avail  = cnt;

   always_comb begin
      w_req   = (stream_width > NEED_STR_WIDTH'(IN_WIDTH)) ? NEED_STR_WIDTH'(IN_WIDTH) : stream_width;
      do_ack  = stream_ack & stream_valid;
      w       = '0;
      if (do_ack)
         w = (CNT_WIDTH'(w_req) > cnt) ? cnt : CNT_WIDTH'(w_req);
      cnt_sh  = cnt - w;
      load    = in_valid & in_ready;
      nbytes  = keep_bytes(in_last, in_keep);
      add     = load ? {1'b0, nbytes, 3'b000} : '0;
      // Shift out first, then insert behind the bits that remain.
      buf_nxt   = (shbuf << w) | (load ? ins : '0);
      cnt_nxt   = cnt_sh + add;
      ended_nxt = ended | (load & in_last);
   end

   lzs_word_align u_align (
      .word   (in_data),
      .nbytes (nbytes),
      .pos    (cnt_sh),
      .ins    (ins)
   );

   always_comb begin
      state_nxt = state;
      if (clr)
         state_nxt = S_FILL;
      else if (state != S_DONE) begin
         if (ended_nxt && cnt_nxt == '0)
            state_nxt = S_DONE;
         else if (ended_nxt)
            state_nxt = S_DRAIN;
         else if (cnt_nxt >= WIN_BITS)
            state_nxt = S_RUN;
         else
            state_nxt = S_FILL;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= S_FILL;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shbuf <= '0;
         cnt   <= '0;
         ended <= 1'b0;
      end else if (clr) begin
         shbuf <= '0;
         cnt   <= '0;
         ended <= 1'b0;
      end else if (state != S_DONE) begin
         shbuf <= buf_nxt;
         cnt   <= cnt_nxt;
         ended <= ended_nxt;
      end
   end

   always @(posedge clk)
      if (rst && !clr && stream_ack && stream_valid)
         assert (stream_width <= NEED_STR_WIDTH'(IN_WIDTH))
            else $warning("stream_width %0d exceeds window, clamped to %0d", stream_width, IN_WIDTH);

endmodule

// File: tb/tb_lzs_bit_stream.sv
// Bench for lzs_bit_stream: directed vector table plus a bit-queue reference
// model feeding a scoreboard that is checked every cycle.
module tb_lzs_bit_stream;
   import lzs_pkg::*;

   logic        clk = 1'b0, rst = 1'b0, clr = 1'b0;
   logic        in_valid = 1'b0, in_last = 1'b0, stream_ack = 1'b0;
   logic [31:0] in_data = '0;
   logic [2:0]  in_keep = '0;
   logic [3:0]  stream_width = '0;
   logic        in_ready, stream_valid, stream_empty;
   logic [12:0] stream_data;
   logic [6:0]  bits_avail;

   lzs_bit_stream dut (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(in_valid), .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
      .in_ready(in_ready), .stream_valid(stream_valid), .stream_data(stream_data),
      .stream_empty(stream_empty), .stream_ack(stream_ack), .stream_width(stream_width),
      .bits_avail(bits_avail)
   );

   always #5 clk = ~clk;

   typedef struct { logic v; logic [12:0] d; logic e; logic r; logic [6:0] a; } exp_t;
   typedef struct {
      logic v; logic [31:0] d; logic [2:0] k; logic l;
      logic a; logic [3:0] w; logic c; exp_t x;
   } vec_t;

   int   checks = 0, errors = 0;
   exp_t sb[$];
   bit   mq[$];
   bit   m_ended = 1'b0, m_done = 1'b0;
   vec_t tbl[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.v = !m_done && (mq.size() >= 13 || (m_ended && mq.size() > 0));
      e.r = !m_done && !m_ended && mq.size() <= 32;
      e.e = m_done;
      e.a = 7'(mq.size());
      e.d = '0;
      for (int i = 0; i < 13; i++)
         if (i < mq.size()) e.d[12-i] = mq[i];
      return e;
   endfunction

   task automatic model_step(input logic v, input logic [31:0] d, input logic [2:0] k,
                             input logic l, input logic a, input logic [3:0] w, input logic c);
      exp_t pre = model_out();
      if (c) begin
         mq.delete(); m_ended = 1'b0; m_done = 1'b0;
      end else if (!m_done) begin
         if (a && pre.v) begin
            int ww = (w > 13) ? 13 : int'(w);
            if (ww > mq.size()) ww = mq.size();
            repeat (ww) void'(mq.pop_front());
         end
         if (v && pre.r) begin
            int nb = l ? ((k > 4) ? 4 : int'(k)) : 4;
            for (int i = 0; i < 8*nb; i++) mq.push_back(d[31-i]);
            if (l) m_ended = 1'b1;
         end
         if (m_ended && mq.size() == 0) m_done = 1'b1;
      end
      sb.push_back(model_out());
   endtask

   task automatic sb_check();
      exp_t e;
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL sb_empty: got no expectation, expected one");
         return;
      end
      e = sb.pop_front();
      chk("sb_valid", 32'(stream_valid), 32'(e.v));
      chk("sb_data",  32'(stream_data),  32'(e.d));
      chk("sb_empty", 32'(stream_empty), 32'(e.e));
      chk("sb_ready", 32'(in_ready),     32'(e.r));
      chk("sb_avail", 32'(bits_avail),   32'(e.a));
   endtask

   task automatic step(input logic v, input logic [31:0] d, input logic [2:0] k,
                       input logic l, input logic a, input logic [3:0] w, input logic c);
      in_valid = v; in_data = d; in_keep = k; in_last = l;
      stream_ack = a; stream_width = w; clr = c;
      model_step(v, d, k, l, a, w, c);
      @(posedge clk); #1;
      sb_check();
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_valid"}, 32'(stream_valid), 32'd0);
      chk({tag, "_data"},  32'(stream_data),  32'd0);
      chk({tag, "_empty"}, 32'(stream_empty), 32'd0);
      chk({tag, "_ready"}, 32'(in_ready),     32'd1);
      chk({tag, "_avail"}, 32'(bits_avail),   32'd0);
   endtask

   function automatic vec_t mk(input logic v, input logic [31:0] d, input logic [2:0] k,
                               input logic l, input logic a, input logic [3:0] w, input logic c,
                               input logic ev, input logic [12:0] ed, input logic ee,
                               input logic er, input logic [6:0] ea);
      vec_t t;
      t.v = v; t.d = d; t.k = k; t.l = l; t.a = a; t.w = w; t.c = c;
      t.x.v = ev; t.x.d = ed; t.x.e = ee; t.x.r = er; t.x.a = ea;
      return t;
   endfunction

   logic        rv, rl, ra, rc;
   logic [31:0] rd;
   logic [2:0]  rk;
   logic [3:0]  rw;

   initial begin
      //             v     data          k     l     a     w     c      valid data      empty ready avail
      tbl[0]  = mk(1'b1, 32'hA5C30F1E, 3'd4, 1'b0, 1'b0, 4'd0,  1'b0,  1'b1, 13'h14B8, 1'b0, 1'b1, 7'd32);
      tbl[1]  = mk(1'b0, 32'h0,        3'd4, 1'b0, 1'b1, 4'd4,  1'b0,  1'b1, 13'h0B86, 1'b0, 1'b1, 7'd28);
      tbl[2]  = mk(1'b1, 32'hDEADBEEF, 3'd4, 1'b0, 1'b1, 4'd13, 1'b1,  1'b0, 13'h0000, 1'b0, 1'b1, 7'd0);
      tbl[3]  = mk(1'b1, 32'hFF000000, 3'd1, 1'b1, 1'b0, 4'd0,  1'b0,  1'b1, 13'h1FE0, 1'b0, 1'b0, 7'd8);
      tbl[4]  = mk(1'b0, 32'h0,        3'd4, 1'b0, 1'b1, 4'd8,  1'b0,  1'b0, 13'h0000, 1'b1, 1'b0, 7'd0);
      tbl[5]  = mk(1'b1, 32'h12345678, 3'd4, 1'b0, 1'b1, 4'd8,  1'b0,  1'b0, 13'h0000, 1'b1, 1'b0, 7'd0);
      tbl[6]  = mk(1'b0, 32'h0,        3'd4, 1'b0, 1'b0, 4'd0,  1'b1,  1'b0, 13'h0000, 1'b0, 1'b1, 7'd0);
      tbl[7]  = mk(1'b1, 32'h12345678, 3'd4, 1'b0, 1'b0, 4'd0,  1'b0,  1'b1, 13'h0246, 1'b0, 1'b1, 7'd32);
      tbl[8]  = mk(1'b1, 32'h9ABCDEF0, 3'd4, 1'b0, 1'b0, 4'd0,  1'b0,  1'b1, 13'h0246, 1'b0, 1'b0, 7'd64);
      tbl[9]  = mk(1'b1, 32'h11111111, 3'd4, 1'b0, 1'b0, 4'd0,  1'b0,  1'b1, 13'h0246, 1'b0, 1'b0, 7'd64);
      tbl[10] = mk(1'b1, 32'h11111111, 3'd4, 1'b0, 1'b1, 4'd13, 1'b0,  1'b1, 13'h1159, 1'b0, 1'b0, 7'd51);
      tbl[11] = mk(1'b1, 32'h11111111, 3'd4, 1'b0, 1'b1, 4'd13, 1'b0,  1'b1, 13'h1C4D, 1'b0, 1'b0, 7'd38);
      tbl[12] = mk(1'b0, 32'h0,        3'd4, 1'b0, 1'b1, 4'd13, 1'b0,  1'b1, 13'h0BCD, 1'b0, 1'b1, 7'd25);
      tbl[13] = mk(1'b0, 32'h0,        3'd4, 1'b0, 1'b1, 4'd15, 1'b0,  1'b0, 13'h1DE0, 1'b0, 1'b1, 7'd12);
      tbl[14] = mk(1'b0, 32'h0,        3'd4, 1'b0, 1'b1, 4'd5,  1'b0,  1'b0, 13'h1DE0, 1'b0, 1'b1, 7'd12);

      #12;
      chk_reset("por");
      @(posedge clk); #1;
      rst = 1'b1;

      for (int i = 0; i < 15; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].k, tbl[i].l, tbl[i].a, tbl[i].w, tbl[i].c);
         chk($sformatf("tbl%0d_valid", i), 32'(stream_valid), 32'(tbl[i].x.v));
         chk($sformatf("tbl%0d_data",  i), 32'(stream_data),  32'(tbl[i].x.d));
         chk($sformatf("tbl%0d_empty", i), 32'(stream_empty), 32'(tbl[i].x.e));
         chk($sformatf("tbl%0d_ready", i), 32'(in_ready),     32'(tbl[i].x.r));
         chk($sformatf("tbl%0d_avail", i), 32'(bits_avail),   32'(tbl[i].x.a));
      end

      // Back-to-back words with a full-window consume every cycle.
      step(1'b0, 32'h0, 3'd4, 1'b0, 1'b0, 4'd0, 1'b1);
      for (int i = 0; i < 6; i++)
         step(1'b1, 32'hC0FFEE00 + 32'(i), 3'd4, 1'b0, 1'b1, 4'd13, 1'b0);

      // End marker with no payload on an empty buffer finishes immediately.
      step(1'b0, 32'h0, 3'd4, 1'b0, 1'b0, 4'd0, 1'b1);
      step(1'b1, 32'hFFFFFFFF, 3'd0, 1'b1, 1'b0, 4'd0, 1'b0);
      chk("marker_empty", 32'(stream_empty), 32'd1);

      // Asynchronous reset in the middle of a running stream.
      step(1'b0, 32'h0, 3'd4, 1'b0, 1'b0, 4'd0, 1'b1);
      step(1'b1, 32'h89ABCDEF, 3'd4, 1'b0, 1'b0, 4'd0, 1'b0);
      step(1'b1, 32'h76543210, 3'd4, 1'b0, 1'b1, 4'd7,  1'b0);
      in_valid = 1'b0; stream_ack = 1'b0;
      rst = 1'b0;
      #2;
      chk_reset("arst");
      mq.delete(); m_ended = 1'b0; m_done = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      step(1'b1, 32'hA5C30F1E, 3'd4, 1'b0, 1'b0, 4'd0, 1'b0);
      chk("arst_restart_data", 32'(stream_data), 32'h14B8);

      // Randomised streams checked against the bit-queue model.
      for (int n = 0; n < 600; n++) begin
         rv = ($urandom_range(0, 3) != 0);
         rd = $urandom;
         rl = ($urandom_range(0, 24) == 0);
         rk = 3'($urandom_range(0, 4));
         ra = ($urandom_range(0, 2) != 0);
         rw = 4'($urandom_range(0, 13));
         rc = m_done && ($urandom_range(0, 2) == 0);
         step(rv, rd, rk, rl, ra, rw, rc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
